// File: rtl/burst_ram.sv
`default_nettype none
// ============================================================================
// Module   : burst_ram
// Summary  : Single-clock RAM with an independent write port and a burst read
//            engine that streams consecutive words over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module burst_ram #(
    parameter  int Width  = 16,
    parameter  int Depth  = 1024,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(Depth),
    localparam int LW     = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [Width-1:0] wrData,
    input  logic             burstStart,
    input  logic [AW-1:0]    burstAddr,
    input  logic [LW-1:0]    burstLen,
    output logic             busy,
    output logic             rdValid,
    input  logic             rdReady,
    output logic [Width-1:0] rdData,
    output logic             rdLast
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [Width-1:0] r_mem [Depth];

    state_t           r_state;
    logic [AW-1:0]    r_ptr;
    logic [LW-1:0]    r_rem;
    logic             r_busy;
    logic             r_valid;
    logic             r_last;
    logic [Width-1:0] r_rdData;

    logic             w_accept;
    logic             w_hs;
    logic             w_advance;
    logic [AW-1:0]    w_next_ptr;
    logic [AW-1:0]    w_fetch_addr;
    logic [Width-1:0] w_mem_word;
    logic             w_bypass_hit;
    logic [Width-1:0] w_fetch_word;

    // A command is only taken while idle and with a non-zero length.
    assign w_accept     = (r_state == ST_IDLE) && burstStart && (burstLen != '0);
    // rdValid is high for the whole RUN state, so a handshake is just RUN & ready.
    assign w_hs         = (r_state == ST_RUN) && rdReady;
    assign w_advance    = w_hs && (r_rem != LW'(1));
    // Explicit compare so non-power-of-two depths wrap correctly.
    assign w_next_ptr   = (r_ptr == AW'(Depth - 1)) ? '0 : r_ptr + AW'(1);
    assign w_fetch_addr = w_accept ? burstAddr : w_next_ptr;
    // Array read happens before this edge's write lands, i.e. read-first;
    // the bypass mux turns it into write-first when enabled.
    assign w_mem_word   = r_mem[w_fetch_addr];
    assign w_bypass_hit = (BYPASS != 0) && wrEn && (wrAddr == w_fetch_addr);
    assign w_fetch_word = w_bypass_hit ? wrData : w_mem_word;

    // Write port: always accepted, independent of the burst engine.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            r_mem[wrAddr] <= wrData;
        end
    end

    // Burst engine: fetches a word on acceptance and on every non-final handshake;
    // without a handshake the output word is held and the array is not re-read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_rem    <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_rdData <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state  <= ST_RUN;
                        r_ptr    <= burstAddr;
                        r_rem    <= burstLen;
                        r_rdData <= w_fetch_word;
                        r_busy   <= 1'b1;
                        r_valid  <= 1'b1;
                        r_last   <= (burstLen == LW'(1));
                    end
                end
                ST_RUN: begin
                    if (w_advance) begin
                        r_ptr    <= w_next_ptr;
                        r_rem    <= r_rem - LW'(1);
                        r_rdData <= w_fetch_word;
                        r_last   <= (r_rem == LW'(2));
                    end else if (w_hs) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_valid  <= 1'b0;
                        r_last   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign rdValid = r_valid;
    assign rdLast  = r_last;
    assign rdData  = r_rdData;

endmodule
`default_nettype wire

// File: doc/burst_ram.md
# burst_ram

Parameterised single-clock RAM with an independent write port and a burst read engine. A single command streams a run of consecutive words out over a valid/ready interface with full back-pressure. Used as the weight/activation store in each network node. Replaces the direct-address combinational-read RAM wherever a processing element consumes contiguous data at one word per cycle.

## Interface
- Width, 16, data word width in bits
- Depth, 1024, number of words; any value ≥ 2 (power of two not required)
- BYPASS, 1, read-during-write to the same address: 1 = new data returned (write-first), 0 = old data returned (read-first)
- AW = $clog2(Depth) (localparam); LW = AW+1 (localparam)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rstn  in  1  asynchronous active-low reset
- wrEn  in  1  write strobe
- wrAddr  in  AW  write address
- wrData  in  Width  write data
- burstStart  in  1  burst command strobe; accepted only when busy=0
- burstAddr  in  AW  first word address of burst (must be < Depth)
- burstLen  in  LW  number of words, 1..2^LW-1; 0 = command ignored
- busy  out  1  burst in progress; no new command accepted
- rdValid  out  1  rdData holds a valid word
- rdReady  in  1  consumer accepts word when rdValid&rdReady
- rdData  out  Width  burst data word
- rdLast  out  1  marks the final word of the burst; qualified by rdValid

## Operation
- Memory array is not reset. Contents are undefined until written.
- Write: on a clock edge with wrEn=1, mem[wrAddr] <= wrData. A write is always accepted, independent of burst state.
- Read array access is synchronous. One read address register feeds a registered output word (rdData).
- States: IDLE, RUN.
- IDLE:
  - burstStart=1 and burstLen≠0: read mem[burstAddr] into rdData, latch ptr=burstAddr, remaining=burstLen, go to RUN.
  - Otherwise hold. busy=0, rdValid=0.
- RUN: busy=1, rdValid=1, rdLast=(remaining==1).
  - Handshake (rdValid&rdReady), remaining>1: ptr advances to the next address, mem[next ptr] is read into rdData, remaining decrements.
  - Handshake with rdLast=1: go to IDLE. rdValid, rdLast and busy clear next cycle.
  - No handshake: rdData, ptr and remaining hold. The memory is not re-read, so a later write to ptr does not alter the held word.
- Address wrap: next ptr = (ptr==Depth-1) ? 0 : ptr+1. Wrap uses an explicit compare.
- burstLen > Depth: the burst keeps wrapping and re-reads words.
- Read-during-write: if a fetch and a write hit the same address in the same cycle:
  - BYPASS=1: rdData gets wrData.
  - BYPASS=0: rdData gets the prior contents.
- burstStart while busy=1: ignored, no effect.
- burstStart with burstLen=0: ignored; stays IDLE.
- Reset asserted mid-burst: burst aborts immediately. After release, state is IDLE; the next command starts fresh.

## Timing
- Reset values: busy=0, rdValid=0, rdLast=0, rdData=0, state=IDLE, ptr=0, remaining=0.
- Command latency: burstStart accepted at edge N; rdValid=1 with word 0 from cycle N+1.
- Throughput: with rdReady held high, one word per cycle. A burst of L words occupies cycles N+1..N+L.
- busy goes high the cycle after acceptance and low the cycle after the final handshake. The earliest next command is accepted at that cycle's edge, giving a 1-cycle bubble between bursts.
- Write visibility:
  - A word written at edge M is visible to a fetch at edge M+1.
  - With BYPASS=1 it is also visible to a fetch at edge M itself.
- rdData, rdValid and rdLast are driven directly from flops. They have no combinational path from rdReady.

## Test plan
- Reset/idle: assert rstn=0 with inputs random → busy=0, rdValid=0, rdLast=0, rdData=0. Release, then pulse burstStart with burstLen=0 → remains IDLE, busy stays 0.
- Basic burst: write mem[i]=i+0x100 for i=0..15. Start addr=4, len=8, rdReady=1 → rdValid cycles N+1..N+8 with data 0x104..0x10B. rdLast only on 0x10B; busy low at N+9.
- Back-pressure: same burst, rdReady toggling 1,0,0,1,… → every word delivered exactly once and in order. rdData stable while rdValid&!rdReady. Total 8 handshakes.
- Wrap and long burst (Depth=16 build):
  - addr=14, len=4 → 0x10E, 0x10F, 0x100, 0x101.
  - len=20 from addr=0 → words 0..15 then 0..3.
- Read-during-write, both BYPASS values: during a burst, write 0xBEEF to the address fetched on that same edge → BYPASS=1 delivers 0xBEEF; BYPASS=0 delivers old value. Also write to the held word's address while rdReady=0 → held word unchanged.
- Command collision/reset: burstStart during RUN with a different addr → ignored, first burst completes intact. Assert rstn mid-burst → outputs return to reset values asynchronously. A new burst after release returns correct data.
